// File: rtl/menu_pkg.sv
// Shared types and constants for the DDR3 clear engine.
package menu_pkg;

    typedef logic [28:0] ddr_addr_t;
    typedef logic [63:0] ddr_data_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_WRITE,
        ST_DONE
    } clear_state_t;

    localparam int unsigned DDR_MAX_BURST = 128;

    // Length of the next burst: the configured maximum, or whatever is left if smaller.
    function automatic logic [7:0] burst_len(input ddr_addr_t remaining, input int unsigned max_burst);
        if (remaining < ddr_addr_t'(max_burst)) begin
            return remaining[7:0];
        end
        return 8'(max_burst);
    endfunction

endpackage

// File: rtl/ddram_clear.sv
// Avalon-MM burst writer that fills a DDR3 word range with a constant pattern.
module ddram_clear
    import menu_pkg::*;
#(
    parameter ddr_addr_t   BASE_ADDR = 29'h0000000,
    parameter ddr_addr_t   LEN_WORDS = 29'h1000000,
    parameter int unsigned MAX_BURST = DDR_MAX_BURST,
    parameter ddr_data_t   FILL      = 64'h0
) (
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic        start,
    input  logic        enable,
    output logic        busy,
    output logic        done,
    output logic [28:0] words_done,
    input  logic        DDRAM_BUSY,
    output logic [7:0]  DDRAM_BURSTCNT,
    output logic [28:0] DDRAM_ADDR,
    output logic [63:0] DDRAM_DIN,
    output logic [7:0]  DDRAM_BE,
    output logic        DDRAM_WE,
    output logic        DDRAM_RD
);

    clear_state_t state_q, state_d;
    ddr_addr_t    addr_q, addr_d;       // start address of the burst on the bus
    logic [7:0]   bcnt_q, bcnt_d;       // burst count of the burst on the bus
    logic [7:0]   beats_q, beats_d;     // beats still to be accepted in this burst
    ddr_addr_t    remain_q, remain_d;   // words still to be accepted in this run
    ddr_addr_t    next_q, next_d;       // start address of the following burst
    ddr_addr_t    words_q, words_d;     // beats accepted in this run

    ddr_addr_t    remain_m1;
    logic [7:0]   len;

    // State and counter registers; RESET returns every output to its idle value.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            addr_q   <= BASE_ADDR;
            bcnt_q   <= 8'd1;
            beats_q  <= '0;
            remain_q <= '0;
            next_q   <= BASE_ADDR;
            words_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            bcnt_q   <= bcnt_d;
            beats_q  <= beats_d;
            remain_q <= remain_d;
            next_q   <= next_d;
            words_q  <= words_d;
        end
    end

    // Next-state logic: burst loading from ARM, or back-to-back on the last beat of a burst.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        bcnt_d    = bcnt_q;
        beats_d   = beats_q;
        remain_d  = remain_q;
        next_d    = next_q;
        words_d   = words_q;
        remain_m1 = remain_q - 29'd1;
        len       = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    words_d  = '0;
                    remain_d = LEN_WORDS;
                    next_d   = BASE_ADDR;
                    state_d  = (LEN_WORDS == '0) ? ST_DONE : ST_ARM;
                end
            end
            ST_ARM: begin
                if (enable) begin
                    len     = burst_len(remain_q, MAX_BURST);
                    addr_d  = next_q;
                    bcnt_d  = len;
                    beats_d = len;
                    next_d  = next_q + ddr_addr_t'(len);
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!DDRAM_BUSY) begin
                    beats_d  = beats_q - 8'd1;
                    remain_d = remain_m1;
                    words_d  = words_q + 29'd1;
                    if (beats_q == 8'd1) begin
                        if (remain_m1 == '0) begin
                            state_d = ST_DONE;
                        end else if (enable) begin
                            // Load the following burst now so WE never drops between bursts.
                            len     = burst_len(remain_m1, MAX_BURST);
                            addr_d  = next_q;
                            bcnt_d  = len;
                            beats_d = len;
                            next_d  = next_q + ddr_addr_t'(len);
                        end else begin
                            state_d = ST_ARM;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy           = (state_q == ST_ARM) || (state_q == ST_WRITE);
    assign done           = (state_q == ST_DONE);
    assign words_done     = words_q;
    assign DDRAM_WE       = (state_q == ST_WRITE);
    assign DDRAM_ADDR     = addr_q;
    assign DDRAM_BURSTCNT = bcnt_q;
    assign DDRAM_DIN      = FILL;
    assign DDRAM_BE       = '1;
    assign DDRAM_RD       = 1'b0;

endmodule

// File: tb/tb_ddram_clear.sv
// Scoreboard bench for ddram_clear: three instances cover a 300-word run, an empty run and address wrap.
module tb_ddram_clear;

    localparam logic [63:0] M_FILL = 64'hDEADBEEF_CAFEF00D;

    typedef struct packed {
        logic [28:0] a;
        logic [7:0]  b;
    } burst_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // main instance: LEN_WORDS=300
    logic        m_start = 0, m_en = 1, m_ddr_busy = 0;
    logic        m_busy, m_done, m_we, m_rd;
    logic [28:0] m_wd, m_addr;
    logic [7:0]  m_bc, m_be;
    logic [63:0] m_din;

    // empty-run instance: LEN_WORDS=0
    logic        z_start = 0;
    logic        z_busy, z_done, z_we, z_rd;
    logic [28:0] z_wd, z_addr;
    logic [7:0]  z_bc, z_be;
    logic [63:0] z_din;

    // wrap instance: BASE_ADDR near the top, LEN_WORDS=256
    logic        w_start = 0;
    logic        w_busy, w_done, w_we, w_rd;
    logic [28:0] w_wd, w_addr;
    logic [7:0]  w_bc, w_be;
    logic [63:0] w_din;

    ddram_clear #(.BASE_ADDR(29'h0), .LEN_WORDS(29'd300), .MAX_BURST(128), .FILL(M_FILL)) u_main (
        .clk_sys(clk), .RESET(rst), .start(m_start), .enable(m_en),
        .busy(m_busy), .done(m_done), .words_done(m_wd),
        .DDRAM_BUSY(m_ddr_busy), .DDRAM_BURSTCNT(m_bc), .DDRAM_ADDR(m_addr),
        .DDRAM_DIN(m_din), .DDRAM_BE(m_be), .DDRAM_WE(m_we), .DDRAM_RD(m_rd)
    );

    ddram_clear #(.BASE_ADDR(29'h0), .LEN_WORDS(29'd0), .MAX_BURST(128), .FILL(64'h0)) u_zero (
        .clk_sys(clk), .RESET(rst), .start(z_start), .enable(1'b1),
        .busy(z_busy), .done(z_done), .words_done(z_wd),
        .DDRAM_BUSY(1'b0), .DDRAM_BURSTCNT(z_bc), .DDRAM_ADDR(z_addr),
        .DDRAM_DIN(z_din), .DDRAM_BE(z_be), .DDRAM_WE(z_we), .DDRAM_RD(z_rd)
    );

    ddram_clear #(.BASE_ADDR(29'h1FFFFF80), .LEN_WORDS(29'd256), .MAX_BURST(128), .FILL(64'h0)) u_wrap (
        .clk_sys(clk), .RESET(rst), .start(w_start), .enable(1'b1),
        .busy(w_busy), .done(w_done), .words_done(w_wd),
        .DDRAM_BUSY(1'b0), .DDRAM_BURSTCNT(w_bc), .DDRAM_ADDR(w_addr),
        .DDRAM_DIN(w_din), .DDRAM_BE(w_be), .DDRAM_WE(w_we), .DDRAM_RD(w_rd)
    );

    int total = 0;
    int bad   = 0;

    burst_t exp_q[$];
    int     exp_done[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_msg(input string nm);
        total++;
        bad++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    // random waitrequest for the main instance, changing just after each rising edge
    bit bp_en = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ddr_busy = bp_en ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Monitor: pops expected bursts/completions and checks bus behaviour on the main instance.
    int          beats_left = 0;
    int          acc = 0;
    logic [28:0] cur_addr = '0, prev_addr = '0;
    logic [7:0]  cur_bc = '0, prev_bc = '0;
    bit          prev_hold = 0;
    always @(negedge clk) begin
        if (rst) begin
            beats_left = 0;
            acc        = 0;
            prev_hold  = 0;
        end else begin
            if (prev_hold) begin
                chk("hold_we", 64'(m_we), 64'd1);
                chk("hold_addr", 64'(m_addr), 64'(prev_addr));
                chk("hold_bc", 64'(m_bc), 64'(prev_bc));
            end
            if (beats_left > 0) begin
                chk("we_in_burst", 64'(m_we), 64'd1);
                chk("addr_in_burst", 64'(m_addr), 64'(cur_addr));
                chk("bc_in_burst", 64'(m_bc), 64'(cur_bc));
            end else if (m_we) begin
                if (exp_q.size() == 0) begin
                    fail_msg("unexpected_burst");
                end else begin
                    burst_t e;
                    e = exp_q.pop_front();
                    chk("burst_addr", 64'(m_addr), 64'(e.a));
                    chk("burst_cnt", 64'(m_bc), 64'(e.b));
                    chk("burst_din", m_din, M_FILL);
                end
                cur_addr   = m_addr;
                cur_bc     = m_bc;
                beats_left = int'(m_bc);
            end
            if (m_we && !m_ddr_busy) begin
                beats_left--;
                acc++;
            end
            prev_hold = m_we && m_ddr_busy;
            prev_addr = m_addr;
            prev_bc   = m_bc;
            if (m_done) begin
                if (exp_done.size() == 0) begin
                    fail_msg("unexpected_done");
                end else begin
                    int ew;
                    ew = exp_done.pop_front();
                    chk("done_words", 64'(m_wd), 64'(ew));
                    chk("done_beats", 64'(acc), 64'(ew));
                end
                acc = 0;
            end
        end
    end

    task automatic push_main();
        exp_q.push_back('{a: 29'd0,   b: 8'd128});
        exp_q.push_back('{a: 29'd128, b: 8'd128});
        exp_q.push_back('{a: 29'd256, b: 8'd44});
        exp_done.push_back(300);
    endtask

    task automatic pulse_m_start();
        @(posedge clk); #1 m_start = 1'b1;
        @(posedge clk); #1 m_start = 1'b0;
    endtask

    // Start a full main run and wait for done; optionally check start-to-done latency.
    task automatic run_main(input bit check_lat);
        bit found;
        found = 0;
        pulse_m_start();
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk("busy_after_start", 64'(m_busy), 64'd1);
                chk("we_after_start", 64'(m_we), 64'd0);
            end
            if (k == 1) chk("first_we", 64'(m_we), 64'd1);
            if (m_done) begin
                if (check_lat) chk("done_latency", 64'(k), 64'd301);
                chk("busy_at_done", 64'(m_busy), 64'd0);
                found = 1;
                break;
            end
        end
        if (!found) fail_msg("timeout_done");
        @(negedge clk);
        chk("done_one_cycle", 64'(m_done), 64'd0);
        chk("idle_busy", 64'(m_busy), 64'd0);
        chk("words_hold", 64'(m_wd), 64'd300);
    endtask

    task automatic wait_wd(input int unsigned lim);
        bit found;
        found = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (m_wd >= 29'(lim)) begin
                found = 1;
                break;
            end
        end
        if (!found) fail_msg("timeout_words");
    endtask

    initial begin
        // reset values
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(m_busy), 64'd0);
        chk("rst_done", 64'(m_done), 64'd0);
        chk("rst_wd", 64'(m_wd), 64'd0);
        chk("rst_we", 64'(m_we), 64'd0);
        chk("rst_bc", 64'(m_bc), 64'd1);
        chk("rst_addr", 64'(m_addr), 64'd0);
        chk("rst_w_addr", 64'(w_addr), 64'h1FFFFF80);
        chk("const_din", m_din, M_FILL);
        chk("const_be", 64'(m_be), 64'hFF);
        chk("const_rd", 64'(m_rd), 64'd0);

        // 300 words, no backpressure
        push_main();
        run_main(1);

        // 300 words, random waitrequest
        bp_en = 1;
        push_main();
        run_main(0);
        bp_en = 0;
        repeat (2) @(negedge clk);

        // enable dropped during burst 2, start pulsed while waiting in ARM
        push_main();
        pulse_m_start();
        wait_wd(140);
        @(posedge clk); #1 m_en = 1'b0;
        begin
            bit found;
            found = 0;
            for (int k = 0; k < 400; k++) begin
                @(negedge clk);
                if (m_busy && !m_we) begin
                    found = 1;
                    break;
                end
            end
            if (!found) fail_msg("timeout_arm");
        end
        chk("arm_words", 64'(m_wd), 64'd256);
        chk("arm_addr", 64'(m_addr), 64'd128);
        chk("arm_bc", 64'(m_bc), 64'd128);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("arm_we_low", 64'(m_we), 64'd0);
            chk("arm_busy", 64'(m_busy), 64'd1);
        end
        pulse_m_start();
        @(negedge clk);
        chk("ignored_start_we", 64'(m_we), 64'd0);
        m_en = 1'b1;
        begin
            bit found;
            found = 0;
            for (int k = 0; k < 400; k++) begin
                @(negedge clk);
                if (m_done) begin
                    found = 1;
                    break;
                end
            end
            if (!found) fail_msg("timeout_done_en");
        end
        @(negedge clk);
        chk("en_words_hold", 64'(m_wd), 64'd300);

        // empty run
        @(posedge clk); #1 z_start = 1'b1;
        @(posedge clk); #1 z_start = 1'b0;
        @(negedge clk);
        chk("zero_done", 64'(z_done), 64'd1);
        chk("zero_busy", 64'(z_busy), 64'd0);
        chk("zero_we", 64'(z_we), 64'd0);
        @(negedge clk);
        chk("zero_done_clr", 64'(z_done), 64'd0);
        chk("zero_we2", 64'(z_we), 64'd0);
        chk("zero_wd", 64'(z_wd), 64'd0);

        // address wrap
        @(posedge clk); #1 w_start = 1'b1;
        @(posedge clk); #1 w_start = 1'b0;
        begin
            bit found;
            found = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (w_we) begin
                    found = 1;
                    break;
                end
            end
            if (!found) fail_msg("timeout_wrap_we");
        end
        chk("wrap_addr1", 64'(w_addr), 64'h1FFFFF80);
        chk("wrap_bc1", 64'(w_bc), 64'd128);
        repeat (128) @(negedge clk);
        chk("wrap_we2", 64'(w_we), 64'd1);
        chk("wrap_addr2", 64'(w_addr), 64'd0);
        chk("wrap_bc2", 64'(w_bc), 64'd128);
        chk("wrap_wd_mid", 64'(w_wd), 64'd128);
        begin
            bit found;
            found = 0;
            for (int k = 0; k < 300; k++) begin
                @(negedge clk);
                if (w_done) begin
                    found = 1;
                    break;
                end
            end
            if (!found) fail_msg("timeout_wrap_done");
        end
        chk("wrap_wd", 64'(w_wd), 64'd256);

        // reset during burst 2, then a clean restart
        push_main();
        pulse_m_start();
        wait_wd(150);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_we", 64'(m_we), 64'd0);
        chk("mid_rst_busy", 64'(m_busy), 64'd0);
        chk("mid_rst_wd", 64'(m_wd), 64'd0);
        chk("mid_rst_addr", 64'(m_addr), 64'd0);
        chk("mid_rst_bc", 64'(m_bc), 64'd1);
        exp_q.delete();
        exp_done.delete();
        push_main();
        run_main(1);

        chk("bursts_left", 64'(exp_q.size()), 64'd0);
        chk("dones_left", 64'(exp_done.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ddram_clear.md
# ddram_clear

Avalon-MM burst writer that fills a DDR3 region with a constant 64-bit pattern so that the next core starts with clean RAM. It sits directly upstream of the DDR3 bridge on the `DDRAM_*` port and replaces the free-running address/write-strobe counter used for clearing. It does not read, reports progress and completion, and finishes all started bursts before stopping.

## Interface
- `BASE_ADDR`, default 29'h0000000: first 64-bit word address to clear.
- `LEN_WORDS`, default 29'h1000000: number of 64-bit words to write; 0 is legal.
- `MAX_BURST`, default 128: beats per burst, range 1..128.
- `FILL`, default 64'h0: data pattern written to every word.

- `clk_sys`  in  1  system clock; all logic on rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a clear; sampled only in IDLE.
- `enable`  in  1  when low, no new burst is started; the current burst completes.
- `busy`  out  1  high from the cycle after an accepted `start` until DONE.
- `done`  out  1  one-cycle pulse when the final beat has been accepted.
- `words_done`  out  29  count of beats accepted in the current run.
- `DDRAM_BUSY`  in  1  Avalon waitrequest.
- `DDRAM_BURSTCNT`  out  8  burst length of the current burst.
- `DDRAM_ADDR`  out  29  burst start word address.
- `DDRAM_DIN`  out  64  always `FILL`.
- `DDRAM_BE`  out  8  always 8'hFF.
- `DDRAM_WE`  out  1  write request, one per beat.
- `DDRAM_RD`  out  1  tied to 0.

## Operation
- FSM states: IDLE, ARM, WRITE, DONE.
- IDLE → ARM on `start`. If `LEN_WORDS`==0, IDLE → DONE instead.
- ARM → WRITE when `enable`=1.
  - Load `DDRAM_ADDR` from the next address.
  - Load `DDRAM_BURSTCNT` as min(`MAX_BURST`, remaining).
  - Load the beat counter with `DDRAM_BURSTCNT`.
- WRITE: `DDRAM_WE`=1.
  - A beat is accepted on any cycle with `DDRAM_WE` & ~`DDRAM_BUSY`.
  - On each accepted beat: decrement the beat counter and remaining count, increment `words_done`.
  - On the last beat of a burst: go to DONE if remaining reaches 0. Otherwise, if `enable`=1, load the next burst in the same cycle so that `DDRAM_WE` stays high; if `enable`=0, go to ARM.
- DONE: pulse `done` for one cycle, drop `busy`, return to IDLE. `words_done` holds its value until the next `start`.
- Address arithmetic: next address = previous burst address + previous burstcount, 29-bit, wrapping modulo 2^29. Remaining count is 29-bit unsigned.
- `start` outside IDLE is ignored. `enable` is ignored in the middle of a burst.

## Timing
- Reset values: `busy`=0, `done`=0, `words_done`=0, `DDRAM_WE`=0, `DDRAM_BURSTCNT`=1, `DDRAM_ADDR`=`BASE_ADDR`, state IDLE.
- `RESET` mid-burst: all outputs return to reset values at that edge. The bridge shares this reset.
- Latency with `enable`=1:
  - `start` at cycle N → `busy` at N+1 → first `DDRAM_WE` at N+2.
  - Last beat accepted at cycle M → `done` and `busy`=0 at M+1.
- While `DDRAM_BUSY`=1: `DDRAM_WE`, `DDRAM_ADDR` and `DDRAM_BURSTCNT` are held stable.
- `DDRAM_ADDR` and `DDRAM_BURSTCNT` change only on the cycle after the last beat of a burst is accepted.
- Throughput: with no backpressure and `enable`=1, one beat per clock, with no gap between bursts.

## Structure
- Shared package `menu_pkg`:
  - `ddr_addr_t` (29-bit) and `ddr_data_t` (64-bit) typedefs.
  - FSM state enum.
  - Constant `DDR_MAX_BURST` = 128.
- No sub-module. The FSM and counters live in a single module.

## Test plan
- `LEN_WORDS`=300, `MAX_BURST`=128, no backpressure: `start` → bursts of 128, 128 and 44 at addresses 0, 128 and 256; 300 contiguous WE cycles; `done` one cycle after the last beat; `words_done`=300.
- Same run with a random `DDRAM_BUSY` at 50%: exactly 300 accepted beats; ADDR, BURSTCNT and WE stable while BUSY is high; burst boundaries identical to the first scenario.
- `enable` dropped mid-burst 2: burst 2 completes, then WE stays 0 in ARM; `enable` raised → burst 3 at address 256 with BURSTCNT=44.
- `LEN_WORDS`=0: `start` → `done` pulse at N+1, no WE ever; `start` pulsed while busy → ignored, total beats unchanged.
- `BASE_ADDR`=29'h1FFFFF80, `LEN_WORDS`=256: second burst address wraps to 0; `words_done`=256.
- `RESET` asserted during burst 2 for 1 cycle: WE=0 and `busy`=0 on the next cycle; a new `start` restarts from `BASE_ADDR` with `words_done`=0.
